// File: rtl/register_file_scoreboard.sv
// Multi-port register file with a per-register pending-load (dirty) scoreboard,
// same-cycle load-return bypass, pending-load counter and sticky hazard flag.
module register_file_scoreboard #(
  parameter int BITWIDTH   = 16,
  parameter int REG_COUNT  = 16,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1,
  localparam int ADDR_W    = $clog2(REG_COUNT)
) (
  input  logic                           clk,
  input  logic                           async_rst_n,
  input  logic                           clk_en,
  input  logic                           Write_En,
  input  logic [ADDR_W-1:0]              Write_Addr,
  input  logic [BITWIDTH-1:0]            Write_Data,
  input  logic                           Dirty_Set,
  input  logic [ADDR_W-1:0]              Dirty_Addr,
  input  logic                           Mem_Write_En,
  input  logic [ADDR_W-1:0]              Mem_Addr,
  input  logic [BITWIDTH-1:0]            Mem_DataIn,
  input  logic [READ_PORTS*ADDR_W-1:0]   Read_Addr,
  output logic [READ_PORTS*BITWIDTH-1:0] Read_Data,
  output logic [READ_PORTS-1:0]          Read_Dirty,
  output logic [REG_COUNT-1:0]           Dirty_Vector,
  output logic [ADDR_W:0]                Pending_Count,
  output logic                           Hazard_Err
);

  localparam int   CNT_W = ADDR_W + 1;
  localparam logic ZR    = (ZERO_REG != 0);

  logic [BITWIDTH-1:0]  regs_q [REG_COUNT];
  logic [BITWIDTH-1:0]  regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] dirty_q, dirty_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 hazard_q, hazard_d;

  // Strobes with register-0 accesses masked out when it is hardwired to zero.
  logic ex_wr, mem_wr, dirty_set;
  assign ex_wr     = Write_En     && !(ZR && (Write_Addr == '0));
  assign mem_wr    = Mem_Write_En && !(ZR && (Mem_Addr   == '0));
  assign dirty_set = Dirty_Set    && !(ZR && (Dirty_Addr == '0));

  always_comb begin
    regs_d  = regs_q;
    dirty_d = dirty_q;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (mem_wr && (Mem_Addr == ADDR_W'(i))) begin
        regs_d[i] = Mem_DataIn;
      end else if (ex_wr && (Write_Addr == ADDR_W'(i))) begin
        regs_d[i] = Write_Data;
      end
      dirty_d[i] = (dirty_set && (Dirty_Addr == ADDR_W'(i))) ||
                   (dirty_q[i] && !(mem_wr && (Mem_Addr == ADDR_W'(i))));
    end
  end

  // Incremental popcount: a set on an already-dirty register adds nothing, and a
  // clear cancelled by a same-register set removes nothing.
  logic cnt_inc, cnt_dec;
  assign cnt_inc = dirty_set && !dirty_q[Dirty_Addr];
  assign cnt_dec = mem_wr && dirty_q[Mem_Addr] &&
                   !(dirty_set && (Dirty_Addr == Mem_Addr));

  always_comb begin
    count_d  = count_q + {{(CNT_W-1){1'b0}}, cnt_inc} - {{(CNT_W-1){1'b0}}, cnt_dec};
    hazard_d = hazard_q ||
               (ex_wr && dirty_q[Write_Addr] && !(Mem_Write_En && (Mem_Addr == Write_Addr)));
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_q[i] <= '0;
      end
      dirty_q  <= '0;
      count_q  <= '0;
      hazard_q <= 1'b0;
    end else if (clk_en) begin
      regs_q   <= regs_d;
      dirty_q  <= dirty_d;
      count_q  <= count_d;
      hazard_q <= hazard_d;
    end
  end

  // Combinational read ports; the load-return bypass ignores clk_en.
  for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_byp;
    logic              rd_zero;
    assign rd_addr = Read_Addr[p*ADDR_W +: ADDR_W];
    assign rd_byp  = Mem_Write_En && (Mem_Addr == rd_addr);
    assign rd_zero = ZR && (rd_addr == '0);
    assign Read_Data[p*BITWIDTH +: BITWIDTH] = rd_zero ? '0 :
                                               rd_byp  ? Mem_DataIn : regs_q[rd_addr];
    assign Read_Dirty[p] = !rd_zero && dirty_q[rd_addr] && !rd_byp;
  end

  assign Dirty_Vector  = dirty_q;
  assign Pending_Count = count_q;
  assign Hazard_Err    = hazard_q;

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Directed bench for register_file_scoreboard: expected values are queued when
// stimulus is driven and popped when the corresponding output is sampled.
module tb_register_file_scoreboard;

  localparam int BITWIDTH   = 16;
  localparam int REG_COUNT  = 16;
  localparam int READ_PORTS = 2;
  localparam int ADDR_W     = 4;
  localparam int W          = 32;

  logic                           clk;
  logic                           async_rst_n;
  logic                           clk_en;
  logic                           Write_En;
  logic [ADDR_W-1:0]              Write_Addr;
  logic [BITWIDTH-1:0]            Write_Data;
  logic                           Dirty_Set;
  logic [ADDR_W-1:0]              Dirty_Addr;
  logic                           Mem_Write_En;
  logic [ADDR_W-1:0]              Mem_Addr;
  logic [BITWIDTH-1:0]            Mem_DataIn;
  logic [READ_PORTS*ADDR_W-1:0]   Read_Addr;
  logic [READ_PORTS*BITWIDTH-1:0] Read_Data;
  logic [READ_PORTS-1:0]          Read_Dirty;
  logic [REG_COUNT-1:0]           Dirty_Vector;
  logic [ADDR_W:0]                Pending_Count;
  logic                           Hazard_Err;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  register_file_scoreboard #(
    .BITWIDTH(BITWIDTH), .REG_COUNT(REG_COUNT), .READ_PORTS(READ_PORTS), .ZERO_REG(1)
  ) dut (
    .clk(clk), .async_rst_n(async_rst_n), .clk_en(clk_en),
    .Write_En(Write_En), .Write_Addr(Write_Addr), .Write_Data(Write_Data),
    .Dirty_Set(Dirty_Set), .Dirty_Addr(Dirty_Addr),
    .Mem_Write_En(Mem_Write_En), .Mem_Addr(Mem_Addr), .Mem_DataIn(Mem_DataIn),
    .Read_Addr(Read_Addr), .Read_Data(Read_Data), .Read_Dirty(Read_Dirty),
    .Dirty_Vector(Dirty_Vector), .Pending_Count(Pending_Count), .Hazard_Err(Hazard_Err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic idle();
    Write_En = 1'b0; Write_Addr = '0; Write_Data = '0;
    Dirty_Set = 1'b0; Dirty_Addr = '0;
    Mem_Write_En = 1'b0; Mem_Addr = '0; Mem_DataIn = '0;
  endtask

  // Advance one edge; inputs and samples sit 1ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reads(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    Read_Addr = {a1, a0};
    #1;
  endtask

  // Scoreboard
  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_next(input string tag, input logic [W-1:0] obs);
    logic [W-1:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%0h expected=<queue empty>", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
    end
  endtask

  function automatic logic [W-1:0] rd(input int p);
    return W'(Read_Data[p*BITWIDTH +: BITWIDTH]);
  endfunction

  initial begin
    async_rst_n = 1'b0;
    clk_en      = 1'b1;
    idle();
    Read_Addr = '0;
    tick(); tick();
    set_reads(4'd5, 4'd3);
    expect_val(0); check_next("reset_dirty_vector", W'(Dirty_Vector));
    expect_val(0); check_next("reset_pending", W'(Pending_Count));
    expect_val(0); check_next("reset_hazard", W'(Hazard_Err));
    expect_val(0); check_next("reset_read0", rd(0));
    async_rst_n = 1'b1;
    tick();

    // Basic execute write, visible the following cycle
    Write_En = 1'b1; Write_Addr = 4'd5; Write_Data = 16'h1234;
    set_reads(4'd5, 4'd3);
    expect_val(0); check_next("no_exec_bypass", rd(0));
    tick(); idle(); set_reads(4'd5, 4'd3);
    expect_val(16'h1234); check_next("basic_read0", rd(0));
    expect_val(0); check_next("basic_dirty0", W'(Read_Dirty[0]));
    expect_val(0); check_next("basic_pending", W'(Pending_Count));

    // Load flow: mark dirty, then return with same-cycle bypass
    Dirty_Set = 1'b1; Dirty_Addr = 4'd3;
    tick(); idle(); set_reads(4'd5, 4'd3);
    expect_val(16'h0008); check_next("load_dirty_vector", W'(Dirty_Vector));
    expect_val(1); check_next("load_pending", W'(Pending_Count));
    expect_val(1); check_next("load_read_dirty1", W'(Read_Dirty[1]));
    Mem_Write_En = 1'b1; Mem_Addr = 4'd3; Mem_DataIn = 16'hBEEF;
    set_reads(4'd5, 4'd3);
    expect_val(16'hBEEF); check_next("bypass_read1", rd(1));
    expect_val(0); check_next("bypass_dirty1", W'(Read_Dirty[1]));
    tick(); idle(); set_reads(4'd5, 4'd3);
    expect_val(0); check_next("load_cleared_vector", W'(Dirty_Vector));
    expect_val(0); check_next("load_cleared_pending", W'(Pending_Count));
    expect_val(16'hBEEF); check_next("load_stored", rd(1));

    // Collision: load-return beats execute write on same address
    Write_En = 1'b1; Write_Addr = 4'd7; Write_Data = 16'h1111;
    Mem_Write_En = 1'b1; Mem_Addr = 4'd7; Mem_DataIn = 16'h2222;
    tick(); idle(); set_reads(4'd7, 4'd5);
    expect_val(16'h2222); check_next("collide_r7", rd(0));

    // Different addresses written in the same cycle
    Write_En = 1'b1; Write_Addr = 4'd10; Write_Data = 16'hA0A0;
    Mem_Write_En = 1'b1; Mem_Addr = 4'd11; Mem_DataIn = 16'hB1B1;
    tick(); idle(); set_reads(4'd10, 4'd11);
    expect_val(16'hA0A0); check_next("dual_write_r10", rd(0));
    expect_val(16'hB1B1); check_next("dual_write_r11", rd(1));

    // Set beats clear on same register
    Dirty_Set = 1'b1; Dirty_Addr = 4'd4;
    tick(); idle();
    Dirty_Set = 1'b1; Dirty_Addr = 4'd4;
    Mem_Write_En = 1'b1; Mem_Addr = 4'd4; Mem_DataIn = 16'h4444;
    tick(); idle(); set_reads(4'd4, 4'd5);
    expect_val(16'h0010); check_next("setclr_vector", W'(Dirty_Vector));
    expect_val(1); check_next("setclr_pending", W'(Pending_Count));
    expect_val(16'h4444); check_next("setclr_data", rd(0));
    expect_val(1); check_next("setclr_dirty", W'(Read_Dirty[0]));

    // Hazard: execute write to a dirty register
    Dirty_Set = 1'b1; Dirty_Addr = 4'd2;
    tick(); idle();
    expect_val(0); check_next("hazard_before", W'(Hazard_Err));
    Write_En = 1'b1; Write_Addr = 4'd2; Write_Data = 16'h00AA;
    tick(); idle(); set_reads(4'd2, 4'd4);
    expect_val(1); check_next("hazard_set", W'(Hazard_Err));
    expect_val(16'h00AA); check_next("hazard_write_done", rd(0));
    expect_val(2); check_next("hazard_pending", W'(Pending_Count));
    tick(); tick(); tick();
    expect_val(1); check_next("hazard_sticky", W'(Hazard_Err));

    // clk_en low: no state change, bypass still live
    clk_en = 1'b0;
    Write_En = 1'b1; Write_Addr = 4'd6; Write_Data = 16'h6666;
    Dirty_Set = 1'b1; Dirty_Addr = 4'd8;
    Mem_Write_En = 1'b1; Mem_Addr = 4'd5; Mem_DataIn = 16'hABCD;
    set_reads(4'd5, 4'd6);
    expect_val(16'hABCD); check_next("hold_bypass", rd(0));
    tick(); idle(); clk_en = 1'b1; set_reads(4'd6, 4'd5);
    expect_val(0); check_next("hold_r6", rd(0));
    expect_val(16'h1234); check_next("hold_r5", rd(1));
    expect_val(16'h0014); check_next("hold_vector", W'(Dirty_Vector));

    // Zero register
    Write_En = 1'b1; Write_Addr = 4'd0; Write_Data = 16'hFFFF;
    Dirty_Set = 1'b1; Dirty_Addr = 4'd0;
    tick(); idle(); set_reads(4'd0, 4'd0);
    expect_val(0); check_next("zero_read", rd(0));
    expect_val(0); check_next("zero_dirty", W'(Read_Dirty[0]));
    expect_val(16'h0014); check_next("zero_vector", W'(Dirty_Vector));
    expect_val(2); check_next("zero_pending", W'(Pending_Count));
    Mem_Write_En = 1'b1; Mem_Addr = 4'd0; Mem_DataIn = 16'h7777;
    set_reads(4'd0, 4'd0);
    expect_val(0); check_next("zero_bypass", rd(1));
    tick(); idle();

    // Reset mid-operation, between edges
    Dirty_Set = 1'b1; Dirty_Addr = 4'd11;
    tick(); idle();
    expect_val(3); check_next("pre_reset_pending", W'(Pending_Count));
    Write_En = 1'b1; Write_Addr = 4'd12; Write_Data = 16'h9999;
    #2;
    async_rst_n = 1'b0;
    set_reads(4'd5, 4'd4);
    expect_val(0); check_next("async_vector", W'(Dirty_Vector));
    expect_val(0); check_next("async_pending", W'(Pending_Count));
    expect_val(0); check_next("async_hazard", W'(Hazard_Err));
    expect_val(0); check_next("async_read0", rd(0));
    expect_val(0); check_next("async_read1", rd(1));
    tick(); idle();
    async_rst_n = 1'b1;
    tick(); set_reads(4'd12, 4'd5);
    expect_val(0); check_next("inflight_dropped", rd(0));

    // Execute write covered by same-address load return raises no hazard
    Dirty_Set = 1'b1; Dirty_Addr = 4'd9;
    tick(); idle();
    Write_En = 1'b1; Write_Addr = 4'd9; Write_Data = 16'h5555;
    Mem_Write_En = 1'b1; Mem_Addr = 4'd9; Mem_DataIn = 16'h6666;
    tick(); idle(); set_reads(4'd9, 4'd5);
    expect_val(0); check_next("covered_no_hazard", W'(Hazard_Err));
    expect_val(16'h6666); check_next("covered_data", rd(0));
    expect_val(0); check_next("covered_pending", W'(Pending_Count));

    // Randomised read-back of quiet registers written this phase
    for (int k = 0; k < 4; k++) begin
      logic [ADDR_W-1:0] a;
      logic [BITWIDTH-1:0] d;
      a = ADDR_W'($urandom_range(1, REG_COUNT - 1));
      d = BITWIDTH'($urandom_range(0, 16'hFFFF));
      Write_En = 1'b1; Write_Addr = a; Write_Data = d;
      expect_val(W'(d));
      tick(); idle(); set_reads(a, 4'd0);
      check_next("rand_readback", rd(0));
    end

    checks++;
    assert (exp_q.size() === 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
Multi-entry, multi-read-port register file with a per-register dirty (pending-load) scoreboard. It is the parametrised successor to the single register cell and sits between decode/issue, the execute writeback path and the load-return path of the core. It adds:
- address decoding and N read ports
- same-cycle load-return bypass
- a deterministic collision priority
- a pending-load counter
- a sticky hazard error flag

Parameters:
BITWIDTH, 16, data width of each register
REG_COUNT, 16, number of registers; power of two, >= 2
READ_PORTS, 2, number of independent combinational read ports
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, never goes dirty
(derived localparam ADDR_W = $clog2(REG_COUNT); not overridable)

Ports:
clk  input  1  clock; all state updates on rising edge
async_rst_n  input  1  asynchronous, active-low reset
clk_en  input  1  global enable; when 0, no state changes (reads still valid)
Write_En  input  1  execute-path write strobe
Write_Addr  input  ADDR_W  execute-path destination
Write_Data  input  BITWIDTH  execute-path data
Dirty_Set  input  1  issue marks a register as awaiting a load
Dirty_Addr  input  ADDR_W  register to mark dirty
Mem_Write_En  input  1  load-return write strobe; clears dirty
Mem_Addr  input  ADDR_W  load-return destination
Mem_DataIn  input  BITWIDTH  load-return data
Read_Addr  input  READ_PORTS*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
Read_Data  output  READ_PORTS*BITWIDTH  packed read data
Read_Dirty  output  READ_PORTS  dirty status per read port
Dirty_Vector  output  REG_COUNT  registered dirty bits, bit i = register i
Pending_Count  output  ADDR_W+1  number of set dirty bits
Hazard_Err  output  1  sticky: an execute write hit a dirty register

Behaviour:
- Reset (async_rst_n low, asynchronous assert, synchronous-safe release) sets:
  - all registers = 0
  - Dirty_Vector = 0
  - Pending_Count = 0
  - Hazard_Err = 0
  Reset mid-operation discards in-flight writes and dirty sets.
- All updates below require clk_en = 1. With clk_en = 0, state holds and outputs reflect the held state plus the bypass rules.
- Data write, effective next edge:
  - Mem_Write_En writes Mem_DataIn to Mem_Addr.
  - Write_En writes Write_Data to Write_Addr.
  - Same address, both strobes: Mem_DataIn wins; Write_Data is dropped.
  - Different addresses: both written in the same cycle.
- Dirty update for register i, next edge:
  - dirty[i] <= (Dirty_Set && Dirty_Addr==i) || (dirty[i] && !(Mem_Write_En && Mem_Addr==i))
  - Set has priority over clear: a load returning while a new load to the same register issues leaves it dirty.
- Pending_Count:
  - Registered; equals the popcount of Dirty_Vector after every edge.
  - Maintained incrementally: +1 on a set of a clean register, -1 on a clear of a dirty register, net 0 when both occur.
  - Never wraps: max REG_COUNT (or REG_COUNT-1 with ZERO_REG).
- Hazard_Err:
  - Set on an edge where clk_en && Write_En && dirty[Write_Addr], and no Mem write to the same address in that cycle.
  - Cleared only by reset. The offending write is still performed.
- Reads are combinational (0-cycle latency). For each port p with address a:
  - Read_Data = Mem_DataIn if Mem_Write_En && Mem_Addr==a (bypass, regardless of clk_en); otherwise register[a].
  - Read_Dirty = dirty[a] && !(Mem_Write_En && Mem_Addr==a).
  - No Write_En bypass: execute data is visible the cycle after the write.
- ZERO_REG=1, register 0:
  - Read_Data = 0 and Read_Dirty = 0, including under bypass.
  - Writes and Dirty_Set are ignored.
  - Never contributes to Pending_Count or Hazard_Err.
- Addresses are always in range by construction (power-of-two REG_COUNT).

Test Plan:
- Reset/basic: deassert reset, Write_En to r5 = 0x1234 -> next cycle Read_Data port0 (addr 5) = 0x1234, Read_Dirty = 0, Pending_Count = 0.
- Load flow:
  - Dirty_Set r3 -> Dirty_Vector = 0x0008, Pending_Count = 1.
  - Next, Mem_Write_En r3 = 0xBEEF -> same cycle port1 (addr 3) reads 0xBEEF with Read_Dirty = 0.
  - Following edge: Dirty_Vector = 0, count = 0.
- Collisions:
  - Write_En and Mem_Write_En both to r7 (0x1111 / 0x2222) -> r7 = 0x2222.
  - Dirty_Set and Mem_Write_En to r4 while r4 dirty -> r4 = data, still dirty, count unchanged.
- Hazard: Dirty_Set r2, then Write_En r2 = 0x00AA -> Hazard_Err = 1 and stays 1; r2 = 0x00AA; only async_rst_n low clears it.
- clk_en and zero register:
  - With clk_en = 0, Write_En r6 -> r6 unchanged.
  - With ZERO_REG = 1, Write_En r0 = 0xFFFF and Dirty_Set r0 -> r0 reads 0, Dirty_Vector[0] = 0.
- Reset mid-operation: with 3 registers dirty and a write in flight, pulse async_rst_n low between edges -> outputs go to 0 immediately, with no clock edge required.
